// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs one TLBP/TLBR/TLBWI/TLBWR at a time against the mmu
// maintenance port, owns the Random register and returns probe/read results to CP0.
module tlb_op_ctrl #(
   parameter int N_TLB_ENTRIES = 32,
   parameter int ENTRY_W       = 128
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   input  logic [1:0]                       req_op,
   output logic                             req_ready,
   output logic                             done,
   output logic                             tlb_updated,
   input  logic [31:0]                      cp0_entry_hi,
   input  logic [31:0]                      cp0_index,
   input  logic [ENTRY_W-1:0]               cp0_entry,
   input  logic [$clog2(N_TLB_ENTRIES)-1:0] cp0_wired,
   input  logic                             cp0_wired_we,
   output logic [$clog2(N_TLB_ENTRIES)-1:0] random,
   output logic [$clog2(N_TLB_ENTRIES)-1:0] tlbrw_index,
   output logic                             tlbrw_we,
   output logic [ENTRY_W-1:0]               tlbrw_wrdata,
   input  logic [ENTRY_W-1:0]               tlbrw_rddata,
   output logic [31:0]                      tlbp_entry_hi,
   input  logic [31:0]                      tlbp_index,
   output logic                             cp0_index_we,
   output logic [31:0]                      cp0_index_wdata,
   output logic                             cp0_entry_we,
   output logic [ENTRY_W-1:0]               cp0_entry_wdata,
   output logic [2:0]                       state_dbg
);

   localparam int IDX_W = $clog2(N_TLB_ENTRIES);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_TLB_ENTRIES - 1);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWI = 2'b10;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PROBE = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [1:0]         op_q;
   logic [31:0]        entry_hi_q;
   logic [IDX_W-1:0]   idx_q;
   logic [ENTRY_W-1:0] entry_q;
   logic [IDX_W-1:0]   random_q;
   logic [31:0]        index_wdata_q;
   logic [ENTRY_W-1:0] entry_wdata_q;
   logic               accept;

   // Handshake: a request transfers on any clock edge where req_valid and req_ready are
   // both high; req_ready is high only in IDLE, so exactly one op is ever in flight and
   // the requester must hold req_valid/req_op stable until it sees the transfer.
   assign accept = req_valid && (state_q == S_IDLE);

   // Random counts down toward Wired and wraps to the top; a Wired write restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         random_q <= IDX_MAX;
      end else if (cp0_wired_we || (random_q <= cp0_wired)) begin
         random_q <= IDX_MAX;
      end else begin
         random_q <= random_q - IDX_W'(1);
      end
   end

   // Operands are frozen at accept so CP0 may change underneath a running op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= OP_TLBP;
         entry_hi_q <= '0;
         idx_q      <= '0;
         entry_q    <= '0;
      end else if (accept) begin
         op_q       <= req_op;
         entry_hi_q <= cp0_entry_hi;
         idx_q      <= (req_op == OP_TLBWR) ? random_q : cp0_index[IDX_W-1:0];
         entry_q    <= cp0_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index_wdata_q <= '0;
         entry_wdata_q <= '0;
      end else begin
         if (state_q == S_PROBE) begin
            index_wdata_q <= {tlbp_index[31], {(31 - IDX_W){1'b0}}, tlbp_index[IDX_W-1:0]};
         end
         if (state_q == S_READ) begin
            entry_wdata_q <= tlbrw_rddata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      done          = 1'b0;
      tlb_updated   = 1'b0;
      tlbrw_we      = 1'b0;
      tlbrw_index   = '0;
      tlbp_entry_hi = '0;
      cp0_index_we  = 1'b0;
      cp0_entry_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               case (req_op)
                  OP_TLBP:  state_d = S_PROBE;
                  OP_TLBR:  state_d = S_READ;
                  default:  state_d = S_WRITE;
               endcase
            end
         end
         S_PROBE: begin
            tlbp_entry_hi = entry_hi_q;
            state_d       = S_DONE;
         end
         S_READ: begin
            tlbrw_index = idx_q;
            state_d     = S_DONE;
         end
         S_WRITE: begin
            tlbrw_index = idx_q;
            tlbrw_we    = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            tlb_updated  = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
            cp0_index_we = (op_q == OP_TLBP);
            cp0_entry_we = (op_q == OP_TLBR);
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign random          = random_q;
   assign tlbrw_wrdata    = entry_q;
   assign cp0_index_wdata = index_wdata_q;
   assign cp0_entry_wdata = entry_wdata_q;
   assign state_dbg       = state_q;

   // Index bits above IDX_W and the mid bits of the probe result carry no meaning here.
   logic unused_bits;
   assign unused_bits = &{1'b0, cp0_index[31:IDX_W], tlbp_index[30:IDX_W]};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural mmu (array + fixed probe table).
module tb_tlb_op_ctrl;

   localparam int IDX_W = 5;
   localparam int EW    = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic [1:0]        req_op;
   logic              req_ready;
   logic              done;
   logic              tlb_updated;
   logic [31:0]       cp0_entry_hi;
   logic [31:0]       cp0_index;
   logic [EW-1:0]     cp0_entry;
   logic [IDX_W-1:0]  cp0_wired;
   logic              cp0_wired_we;
   logic [IDX_W-1:0]  random;
   logic [IDX_W-1:0]  tlbrw_index;
   logic              tlbrw_we;
   logic [EW-1:0]     tlbrw_wrdata;
   logic [EW-1:0]     tlbrw_rddata;
   logic [31:0]       tlbp_entry_hi;
   logic [31:0]       tlbp_index;
   logic              cp0_index_we;
   logic [31:0]       cp0_index_wdata;
   logic              cp0_entry_we;
   logic [EW-1:0]     cp0_entry_wdata;
   logic [2:0]        state_dbg;

   tlb_op_ctrl #(.N_TLB_ENTRIES(32), .ENTRY_W(EW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
      .done(done), .tlb_updated(tlb_updated), .cp0_entry_hi(cp0_entry_hi),
      .cp0_index(cp0_index), .cp0_entry(cp0_entry), .cp0_wired(cp0_wired),
      .cp0_wired_we(cp0_wired_we), .random(random), .tlbrw_index(tlbrw_index),
      .tlbrw_we(tlbrw_we), .tlbrw_wrdata(tlbrw_wrdata), .tlbrw_rddata(tlbrw_rddata),
      .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index), .cp0_index_we(cp0_index_we),
      .cp0_index_wdata(cp0_index_wdata), .cp0_entry_we(cp0_entry_we),
      .cp0_entry_wdata(cp0_entry_wdata), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // mmu model: writes land on the clock edge, reads and probes answer combinationally
   logic [EW-1:0]        tlb_mem [32];
   int                   we_count = 0;
   logic [IDX_W+EW-1:0]  last_write = '0;

   always @(posedge clk) begin
      if (tlbrw_we) begin
         tlb_mem[tlbrw_index] <= tlbrw_wrdata;
         we_count             <= we_count + 1;
         last_write           <= {tlbrw_index, tlbrw_wrdata};
      end
   end

   assign tlbrw_rddata = tlb_mem[tlbrw_index];
   assign tlbp_index   = (tlbp_entry_hi == 32'h1234_5000) ? 32'h0000_3C07 : 32'h8000_0000;

   // scoreboard
   logic [IDX_W+EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   localparam logic [EW-1:0] E1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [EW-1:0] E2 = 128'hA5A5_0001_C3C3_0002_0F0F_0003_F0F0_0004;
   localparam logic [EW-1:0] E3 = 128'h0000_0099_0000_0098_0000_0097_0000_0096;
   localparam logic [EW-1:0] E4 = 128'hDEAD_0004_DEAD_0004_DEAD_0004_DEAD_0004;
   localparam logic [EW-1:0] E5 = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Presents one request in IDLE, lets it be accepted, then scrambles the CP0 inputs.
   task automatic start(input logic [1:0] op, input logic [31:0] idx,
                        input logic [31:0] ehi, input logic [EW-1:0] ent);
      check("ready_before_accept", req_ready, 1);
      req_valid    = 1'b1;
      req_op       = op;
      cp0_index    = idx;
      cp0_entry_hi = ehi;
      cp0_entry    = ent;
      step();
      req_valid    = 1'b0;
      req_op       = ~op;
      cp0_index    = 32'h0000_001E;
      cp0_entry_hi = 32'hDEAD_BEEF;
      cp0_entry    = '1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; cp0_entry_hi = '0; cp0_index = '0;
      cp0_entry = '0; cp0_wired = '0; cp0_wired_we = 1'b0;
      step(); step();

      // reset state
      check("rst_random", random, 31);
      check("rst_ready", req_ready, 1);
      check("rst_done", done, 0);
      check("rst_we", tlbrw_we, 0);
      check("rst_index", tlbrw_index, 0);
      check("rst_probe_hi", tlbp_entry_hi, 0);
      check("rst_cp0_we", {cp0_index_we, cp0_entry_we}, 0);
      check("rst_wdata", {cp0_index_wdata, cp0_entry_wdata}, 0);
      check("rst_state", state_dbg, 0);
      rst = 1'b0;
      step();
      check("random_first_dec", random, 30);

      // TLBWI to index 5 with upper Index bits set
      exp_q.push_back({5'd5, E1});
      start(2'b10, 32'hFFFF_FFE5, 32'h0, E1);
      check("wi_we", tlbrw_we, 1);
      check("wi_index", tlbrw_index, 5);
      check("wi_wrdata", tlbrw_wrdata, E1);
      check("wi_ready_busy", req_ready, 0);
      check("wi_no_early_done", done, 0);
      step();
      check("wi_done", done, 1);
      check("wi_updated", tlb_updated, 1);
      check("wi_we_once", tlbrw_we, 0);
      check("wi_no_cp0_we", {cp0_index_we, cp0_entry_we}, 0);
      step();
      check("wi_done_pulse", {done, tlb_updated}, 0);
      check("wi_idle_ready", req_ready, 1);
      check("wi_idle_index", tlbrw_index, 0);
      check("wi_write_count", we_count, 1);
      check("wi_write_data", last_write, exp_q.pop_front());

      // TLBWI(3,E2) then TLBR 3
      exp_q.push_back({5'd3, E2});
      start(2'b10, 32'h3, 32'h0, E2);
      step(); step();
      check("wi3_write", last_write, exp_q.pop_front());
      start(2'b01, 32'h3, 32'h0, '0);
      check("rd_index", tlbrw_index, 3);
      check("rd_no_we", tlbrw_we, 0);
      step();
      check("rd_entry_we", cp0_entry_we, 1);
      check("rd_entry_wdata", cp0_entry_wdata, E2);
      check("rd_done", {done, tlb_updated, cp0_index_we}, 3'b100);
      step();
      check("rd_entry_we_pulse", cp0_entry_we, 0);
      check("rd_no_write", we_count, 2);

      // TLBP hit on entry 7, then miss
      start(2'b00, 32'h0, 32'h1234_5000, '0);
      check("tp_entry_hi", tlbp_entry_hi, 32'h1234_5000);
      check("tp_no_we", tlbrw_we, 0);
      step();
      check("tp_hit_we", cp0_index_we, 1);
      check("tp_hit_wdata", cp0_index_wdata, 32'h0000_0007);
      check("tp_done", {done, tlb_updated, cp0_entry_we}, 3'b100);
      step();
      check("tp_we_pulse", cp0_index_we, 0);
      start(2'b00, 32'h0, 32'h0BAD_0000, '0);
      step();
      check("tp_miss_we", cp0_index_we, 1);
      check("tp_miss_wdata", cp0_index_wdata, 32'h8000_0000);
      step();

      // back-to-back: req_valid held through two TLBWI ops
      exp_q.push_back({5'd9, E3});
      req_valid = 1'b1; req_op = 2'b10; cp0_index = 32'h9; cp0_entry = E3;
      check("b2b_ready0", req_ready, 1);
      step();
      check("b2b_ready1", req_ready, 0);
      step();
      check("b2b_ready2", req_ready, 0);
      step();
      check("b2b_ready3", req_ready, 1);
      step();
      check("b2b_second_accept", tlbrw_we, 1);
      req_valid = 1'b0;
      step(); step();
      check("b2b_write_count", we_count, 4);
      check("b2b_write_data", last_write, exp_q.pop_front());

      // Random with wired=4: restart to 31, walk down to 4, wrap
      cp0_wired = 5'd4; cp0_wired_we = 1'b1;
      step();
      cp0_wired_we = 1'b0;
      check("rnd_wired_we", random, 31);
      for (int k = 1; k <= 27; k++) begin
         step();
         check("rnd_walk", random, 31 - k);
      end
      step();
      check("rnd_wrap", random, 31);
      for (int k = 0; k < 19; k++) step();
      check("rnd_at_12", random, 12);

      // TLBWR latches Random=12 at accept
      exp_q.push_back({5'd12, E5});
      start(2'b11, 32'h1, 32'h0, E5);
      check("wr_index", tlbrw_index, 12);
      check("wr_random_moved", random, 11);
      check("wr_we", tlbrw_we, 1);
      step();
      check("wr_updated", tlb_updated, 1);
      step();
      check("wr_write_data", last_write, exp_q.pop_front());

      // Wired=31 pins Random
      cp0_wired = 5'd31; cp0_wired_we = 1'b1;
      step();
      cp0_wired_we = 1'b0;
      check("rnd_pin0", random, 31);
      step();
      check("rnd_pin1", random, 31);
      step();
      check("rnd_pin2", random, 31);
      cp0_wired = 5'd0;

      // reset while in WRITE aborts the op
      start(2'b10, 32'h2, 32'h0, E4);
      check("abort_in_write", tlbrw_we, 1);
      rst = 1'b1;
      #1;
      check("abort_we_drop", tlbrw_we, 0);
      check("abort_ready", req_ready, 1);
      check("abort_random", random, 31);
      step();
      rst = 1'b0;
      step();
      check("abort_no_done", {done, tlb_updated, cp0_index_we, cp0_entry_we}, 0);
      step();
      check("abort_no_write", we_count, 5);
      check("abort_no_done2", done, 0);
      check("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
